fifo_rr_drain_ctrl: RTL and testbench



---
 rtl/fifo_rr_drain_ctrl_pkg.sv | 28 ++
 rtl/fifo_rr_drain_ctrl_rr_arb.sv | 48 ++++
 rtl/fifo_rr_drain_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fifo_rr_drain_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_drain_ctrl_pkg.sv
// Shared definitions for the round-robin FIFO drain controller:
// default sizing, FIFO word width helper and the controller state encoding.
package fifo_rr_drain_ctrl_pkg;

    // Default element width and elements per FIFO word (match the FIFOs).
    localparam int BW_DEF       = 4;
    localparam int SIMD_DEF     = 1;

    // Default number of arbitrated FIFOs and width of the source index.
    localparam int NUM_FIFO_DEF = 4;
    localparam int ID_W_DEF     = 2;

    // Width of the exported state value.
    localparam int STATE_W      = 2;

    // Controller states; the numeric values are visible on the debug port.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    // Width of one FIFO output word: simd elements of bw bits each.
    function automatic int word_w(input int simd_n, input int bw_n);
        return simd_n * bw_n;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_ctrl_rr_arb.sv
// Combinational round-robin picker. The search starts one index past
// i_rr_last and wraps, so the most recently served requester has the
// lowest priority on the next pick.
module fifo_rr_drain_ctrl_rr_arb
    import fifo_rr_drain_ctrl_pkg::*;
#(
    parameter int NUM_FIFO = NUM_FIFO_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic [NUM_FIFO-1:0] i_req,
    input  logic [ID_W-1:0]     i_rr_last,
    output logic [NUM_FIFO-1:0] o_gnt,
    output logic [ID_W-1:0]     o_gnt_idx,
    output logic                o_any
);

    int w_best;
    int w_pick;

    // Pick the requester with the smallest circular distance past i_rr_last.
    always_comb begin
        int v_dist;
        v_dist = 0;
        w_best = NUM_FIFO;
        w_pick = 0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            v_dist = i - int'(i_rr_last) - 1;
            if (v_dist < 0) begin
                v_dist = v_dist + NUM_FIFO;
            end
            if (i_req[i] && (v_dist < w_best)) begin
                w_best = v_dist;
                w_pick = i;
            end
        end
    end

    // Turn the winning index into the one-hot grant and the summary flag.
    always_comb begin
        o_any     = (w_best < NUM_FIFO);
        o_gnt_idx = ID_W'(w_pick);
        o_gnt     = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            o_gnt[i] = o_any && (w_pick == i);
        end
    end

endmodule

// File: rtl/fifo_rr_drain_ctrl.sv
// Round-robin drain controller: reads NUM_FIFO FIFOs that share this clock
// into one registered valid/ready stream, tagging each word with its source.
//
// Output handshake: out_data/out_src are meaningful while out_valid=1; a word
// transfers on any rising clk edge where out_valid && out_ready, and while
// out_valid && !out_ready the word is held unchanged.
//
// The FIFO empty flag lags a read by one cycle, so a FIFO read in one cycle
// is blocked for the next cycle to avoid reading past its last word.
module fifo_rr_drain_ctrl
    import fifo_rr_drain_ctrl_pkg::*;
#(
    parameter int bw       = BW_DEF,
    parameter int simd     = SIMD_DEF,
    parameter int NUM_FIFO = NUM_FIFO_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_FIFO-1:0]          mask,
    input  logic [NUM_FIFO-1:0]          fifo_empty,
    input  logic [NUM_FIFO*simd*bw-1:0]  fifo_data,
    output logic [NUM_FIFO-1:0]          fifo_rd,
    output logic [simd*bw-1:0]           out_data,
    output logic [ID_W-1:0]              out_src,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [15:0]                  xfer_cnt,
    output logic [STATE_W-1:0]           dbg_state
);

    localparam int WORD_W = word_w(simd, bw);

    // Registered state.
    state_e              r_state;
    logic [NUM_FIFO-1:0] r_blk;
    logic [ID_W-1:0]     r_rr_last;
    logic [WORD_W-1:0]   r_out_data;
    logic [ID_W-1:0]     r_out_src;
    logic                r_out_valid;
    logic [15:0]         r_xfer_cnt;

    // Combinational decisions for the current cycle.
    logic [NUM_FIFO-1:0] w_elig;
    logic [NUM_FIFO-1:0] w_gnt;
    logic [ID_W-1:0]     w_gnt_idx;
    logic                w_any;
    logic                w_can_load;
    logic                w_accept;
    logic                w_grant;
    logic [WORD_W-1:0]   w_sel_data;

    // A FIFO may be read when it has data, is enabled and was not just read.
    assign w_elig     = ~fifo_empty & mask & ~r_blk;
    assign w_can_load = !r_out_valid || out_ready;
    assign w_accept   = r_out_valid && out_ready;
    // Grants only in RUN with en still high; dropping en stops reads at once.
    assign w_grant    = (r_state == ST_RUN) && en && w_can_load && w_any;

    fifo_rr_drain_ctrl_rr_arb #(
        .NUM_FIFO (NUM_FIFO),
        .ID_W     (ID_W)
    ) u_rr_arb (
        .i_req     (w_elig),
        .i_rr_last (r_rr_last),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Route the granted FIFO's head word to the output register input.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = fifo_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // Read strobe is the grant itself, issued in the same cycle as the pick.
    assign fifo_rd = w_grant ? w_gnt : '0;

    // Run/stop sequencing; STOP waits for the held word to leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (en) begin
                        r_state <= ST_RUN;
                    end else if (!r_out_valid || out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Block each FIFO for the single cycle after it was read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= '0;
        end else begin
            r_blk <= fifo_rd;
        end
    end

    // Remember the last granted index; it holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= ID_W'(NUM_FIFO - 1);
        end else if (w_grant) begin
            r_rr_last <= w_gnt_idx;
        end
    end

    // Output register: reload on grant, otherwise drain on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_src   <= w_gnt_idx;
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count accepted output words, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_accept) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fifo_rr_drain_ctrl.sv
// Bench for fifo_rr_drain_ctrl: directed phases from reset followed by random
// traffic, all compared every cycle against a behavioural model of the
// scheduling rules, plus a word scoreboard and literal spot checks.
module tb_fifo_rr_drain_ctrl;

    localparam int N = 4;
    localparam int W = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    // ---------------- clock / reset / DUT ----------------
    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   mask;
    logic [N-1:0]   fifo_empty;
    logic [N*W-1:0] fifo_data;
    logic [N-1:0]   fifo_rd;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic [15:0]    xfer_cnt;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    fifo_rr_drain_ctrl #(
        .bw       (W),
        .simd     (1),
        .NUM_FIFO (N),
        .ID_W     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mask       (mask),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .xfer_cnt   (xfer_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- counters and scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];

    // ---------------- behavioural model ----------------
    int         m_mode;
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_src;
    int         m_last;
    int         m_prev;
    int         m_cnt;

    // Last observed DUT outputs (sampled before the edge inside step).
    logic [N-1:0] obs_rd;
    logic         obs_valid;
    logic [W-1:0] obs_data;
    logic [1:0]   obs_src;
    logic         obs_busy;
    logic [15:0]  obs_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = N - 1;
        m_prev  = -1;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    // One cycle: entered just after a falling edge with inputs applied.
    task automatic step();
        int           g;
        int           idx;
        bit           can_load;
        bit           acc;
        logic [N-1:0] exp_rd;
        logic [5:0]   sb_word;
        int           n_mode;
        bit           n_valid;
        logic [W-1:0] n_data;
        int           n_src;
        int           n_last;
        int           n_cnt;
        #1;
        obs_rd    = fifo_rd;
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_src   = out_src;
        obs_busy  = busy;
        obs_cnt   = xfer_cnt;

        // Pick: first ready FIFO after the last served one, circularly.
        g = -1;
        can_load = !m_valid || out_ready;
        if (m_mode == M_RUN && en && can_load) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && !fifo_empty[idx] && mask[idx] && idx != m_prev) g = idx;
            end
        end
        exp_rd = (g >= 0) ? N'(1 << g) : '0;

        chk("fifo_rd", obs_rd, exp_rd);
        chk("out_valid", obs_valid, m_valid);
        chk("out_data", obs_data, m_data);
        chk("out_src", obs_src, m_src);
        chk("busy", obs_busy, (m_mode != M_IDLE));
        chk("xfer_cnt", obs_cnt, m_cnt);
        chk("state", dbg_state, m_mode);

        // Scoreboard: every word the DUT hands over must be the one granted.
        if (obs_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_word: accepted src=%0d data=%0h with nothing expected at %0t",
                         obs_src, obs_data, $time);
            end else begin
                sb_word = exp_q.pop_front();
                chk("sb_word", {obs_src, obs_data}, sb_word);
            end
        end

        acc     = m_valid && out_ready;
        n_valid = m_valid;
        n_data  = m_data;
        n_src   = m_src;
        n_last  = m_last;
        n_cnt   = m_cnt;
        if (g >= 0) begin
            n_valid = 1'b1;
            n_data  = W'(fifo_data >> (g * W));
            n_src   = g;
            n_last  = g;
            exp_q.push_back({2'(g), n_data});
        end else if (acc) begin
            n_valid = 1'b0;
        end
        if (acc) n_cnt = (m_cnt + 1) % 65536;

        n_mode = m_mode;
        if (m_mode == M_IDLE) n_mode = en ? M_RUN : M_IDLE;
        else if (m_mode == M_RUN) n_mode = en ? M_RUN : M_STOP;
        else if (en) n_mode = M_RUN;
        else if (!m_valid || out_ready) n_mode = M_IDLE;

        @(posedge clk);
        m_mode  = n_mode;
        m_valid = n_valid;
        m_data  = n_data;
        m_src   = n_src;
        m_last  = n_last;
        m_prev  = g;
        m_cnt   = n_cnt;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int viol;
        int words;
        bit prev_rd1;
        logic [W-1:0] held_d;
        logic [1:0]   held_s;
        logic [15:0]  base;

        rst_n      = 1'b0;
        en         = 1'b0;
        mask       = '0;
        fifo_empty = '1;
        fifo_data  = '0;
        out_ready  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Phase 1: FIFOs 0 and 2 non-empty, full throughput alternation.
        en         = 1'b1;
        mask       = 4'b1111;
        fifo_empty = 4'b1010;
        fifo_data  = {4'h4, 4'h3, 4'h2, 4'h1};
        out_ready  = 1'b1;
        step(); chk("p1_c0_rd", obs_rd, 4'b0000);
        step(); chk("p1_c1_rd", obs_rd, 4'b0001);
        step(); chk("p1_c2_rd", obs_rd, 4'b0100);
                chk("p1_c2_src", obs_src, 0);
                chk("p1_c2_data", obs_data, 4'h1);
        step(); chk("p1_c3_rd", obs_rd, 4'b0001);
                chk("p1_c3_src", obs_src, 2);
                chk("p1_c3_data", obs_data, 4'h3);
        step(); chk("p1_c4_rd", obs_rd, 4'b0100);
                chk("p1_c4_valid", obs_valid, 1);
                chk("p1_c4_cnt", obs_cnt, 2);

        // Phase 2: only FIFO 1 has data; never read twice in a row.
        fifo_empty = 4'b1101;
        viol = 0;
        words = 0;
        prev_rd1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_rd[1] && prev_rd1) viol++;
            prev_rd1 = obs_rd[1];
            if (obs_valid && obs_src == 2'd1) words++;
        end
        chk("single_b2b", viol, 0);
        chk("single_words", words, 6);

        // Phase 3: backpressure with all FIFOs holding data.
        fifo_empty = 4'b0000;
        out_ready  = 1'b0;
        step();
        step();
        held_d = obs_data;
        held_s = obs_src;
        chk("bp_src", held_s, 2);
        chk("bp_data", held_d, 4'h3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_no_rd", obs_rd, 0);
            chk("bp_hold_data", obs_data, held_d);
            chk("bp_hold_src", obs_src, held_s);
        end
        out_ready = 1'b1;
        step();
        base = obs_cnt;
        repeat (3) step();
        chk("bp_cnt_step", obs_cnt, 16'(base + 16'd3));

        // Phase 4: only FIFO 2 enabled.
        mask = 4'b0100;
        step();
        step();
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_valid && obs_src != 2'd2) viol++;
            if ((obs_rd & 4'b1011) != 0) viol++;
        end
        chk("mask_only2", viol, 0);

        // Phase 5: drop en while a word is stalled.
        mask      = 4'b1111;
        out_ready = 1'b0;
        step();
        step();
        en = 1'b0;
        step(); chk("stop_rd0", obs_rd, 0);
        step(); chk("stop_busy", obs_busy, 1);
                chk("stop_rd1", obs_rd, 0);
                chk("stop_valid", obs_valid, 1);
        out_ready = 1'b1;
        step(); chk("stop_accept_busy", obs_busy, 1);
        out_ready = 1'b0;
        step(); chk("idle_busy", obs_busy, 0);
                chk("idle_valid", obs_valid, 0);

        // Phase 6: asynchronous reset while a word is held.
        en = 1'b1;
        repeat (3) step();
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", xfer_cnt, 0);
        chk("mid_rst_rd", fifo_rd, 0);
        chk("mid_rst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        fifo_empty = 4'b1001;
        out_ready  = 1'b1;
        step(); chk("post_rst_idle_rd", obs_rd, 0);
        step(); chk("post_rst_first", obs_rd, 4'b0010);

        // Phase 7: random traffic.
        for (int i = 0; i < 3000; i++) begin
            en         = ($urandom_range(0, 15) != 0);
            mask       = ($urandom_range(0, 3) == 0) ? N'($urandom) : 4'b1111;
            fifo_empty = N'($urandom) & N'($urandom);
            fifo_data  = (N*W)'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
